ecc_secded_pipe: RTL and testbench

Parametrised, pipelined SEC-DED Hsiao-style ECC engine for the memory datapath.
- Independent encode and decode channels, each with a valid/ready handshake.
- Correction can be enabled or disabled at run time.
- Saturating correctable and uncorrectable error counters for scrub and health reporting.
- Sits between the client datapath and the SRAM macro wrappers. DATA_W=23 and PAR_W=6 give a 29-bit codeword.

---
 rtl/ecc_secded_pkg.sv | 61 ++++++
 rtl/ecc_secded_syn.sv | 17 +
 rtl/ecc_secded_pipe.sv | 165 ++++++++++++++++
 tb/tb_ecc_secded_pipe.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_secded_pkg.sv
// H-matrix construction helpers shared by the SEC-DED encoder and decoder.
package ecc_secded_pkg;

    localparam int unsigned MAX_DATA_W = 120;
    localparam int unsigned MAX_PAR_W  = 16;
    localparam int unsigned MAX_CW_W   = MAX_DATA_W + MAX_PAR_W;

    typedef logic [MAX_PAR_W-1:0]               col_t;
    typedef logic [MAX_CW_W-1:0][MAX_PAR_W-1:0] col_tab_t;

    function automatic bit is_data_col(int unsigned v);
        return ($countones(v) >= 3) && (($countones(v) % 2) == 1);
    endfunction

    function automatic int unsigned odd_col_count(int unsigned par_w);
        int unsigned n = 0;
        for (int unsigned v = 1; v < (32'd1 << par_w); v++) begin
            if (is_data_col(v)) n++;
        end
        return n;
    endfunction

    // i-th smallest odd-weight (>=3) value of par_w bits
    function automatic col_t col_of(int unsigned i, int unsigned par_w);
        int unsigned n = 0;
        col_t        c = '0;
        for (int unsigned v = 1; v < (32'd1 << par_w); v++) begin
            if (is_data_col(v)) begin
                if (n == i) c = MAX_PAR_W'(v);
                n++;
            end
        end
        return c;
    endfunction

    function automatic col_tab_t build_cols(int unsigned data_w, int unsigned par_w);
        col_tab_t t = '0;
        for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
            if (i < data_w) t[i] = col_of(i, par_w);
        end
        for (int unsigned j = 0; j < MAX_PAR_W; j++) begin
            if (j < par_w) t[data_w + j] = MAX_PAR_W'(1) << j;
        end
        return t;
    endfunction

    function automatic col_t calc_parity(logic [MAX_DATA_W-1:0] d, col_tab_t cols,
                                         int unsigned data_w);
        col_t p = '0;
        for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
            if ((i < data_w) && d[i]) p = p ^ cols[i];
        end
        return p;
    endfunction

    function automatic bit cfg_ok(int unsigned data_w, int unsigned par_w);
        return (data_w >= 2) && (data_w <= MAX_DATA_W) && (par_w >= 3) &&
               (par_w <= MAX_PAR_W) && (data_w <= odd_col_count(par_w));
    endfunction

endpackage

// File: rtl/ecc_secded_syn.sv
// Combinational parity/syndrome generator: recomputed parity XOR supplied parity.
module ecc_secded_syn
    import ecc_secded_pkg::*;
#(
    parameter int unsigned DATA_W = 23,
    parameter int unsigned PAR_W  = 6
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [PAR_W-1:0]  i_par,
    output logic [PAR_W-1:0]  o_syn_c
);

    localparam col_tab_t COLS = build_cols(DATA_W, PAR_W);

    assign o_syn_c = PAR_W'(calc_parity(MAX_DATA_W'(i_data), COLS, DATA_W)) ^ i_par;

endmodule

// File: rtl/ecc_secded_pipe.sv
// Pipelined SEC-DED engine: 1-stage encoder, 2-stage decoder, saturating error counters.
module ecc_secded_pipe
    import ecc_secded_pkg::*;
#(
    parameter  int unsigned DATA_W = 23,
    parameter  int unsigned PAR_W  = 6,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned CW_W   = DATA_W + PAR_W,
    localparam int unsigned LOC_W  = $clog2(CW_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_valid,
    output logic              enc_ready,
    input  logic [DATA_W-1:0] enc_data,
    output logic              enc_cw_valid,
    input  logic              enc_cw_ready,
    output logic [CW_W-1:0]   enc_cw,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [CW_W-1:0]   dec_cw,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ce,
    output logic              out_ue,
    output logic [LOC_W-1:0]  out_loc,
    input  logic              correct_en,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  ce_cnt,
    output logic [CNT_W-1:0]  ue_cnt
);

    localparam col_tab_t COLS = build_cols(DATA_W, PAR_W);

    if (!cfg_ok(DATA_W, PAR_W)) begin : g_cfg_check
        $error("ecc_secded_pipe: DATA_W exceeds available odd-weight PAR_W columns");
    end

    logic [PAR_W-1:0]  w_enc_par;
    logic [PAR_W-1:0]  w_dec_syn;
    logic              w_s2_ready;
    logic              w_hit;
    logic [LOC_W-1:0]  w_loc;
    logic [DATA_W-1:0] w_flip;

    logic              r_enc_cw_valid;
    logic [CW_W-1:0]   r_enc_cw;
    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [PAR_W-1:0]  r_s1_syn;
    logic              r_s1_cen;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_ce;
    logic              r_out_ue;
    logic [LOC_W-1:0]  r_out_loc;
    logic [CNT_W-1:0]  r_ce_cnt;
    logic [CNT_W-1:0]  r_ue_cnt;

    ecc_secded_syn #(.DATA_W(DATA_W), .PAR_W(PAR_W)) u_enc_syn (
        .i_data  (enc_data),
        .i_par   (PAR_W'(0)),
        .o_syn_c (w_enc_par)
    );

    ecc_secded_syn #(.DATA_W(DATA_W), .PAR_W(PAR_W)) u_dec_syn (
        .i_data  (dec_cw[DATA_W-1:0]),
        .i_par   (dec_cw[CW_W-1:DATA_W]),
        .o_syn_c (w_dec_syn)
    );

    assign enc_ready  = ~r_enc_cw_valid | enc_cw_ready;
    assign w_s2_ready = ~r_out_valid | out_ready;
    assign dec_ready  = ~r_s1_valid | w_s2_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enc_cw_valid <= 1'b0;
            r_enc_cw       <= '0;
        end else if (enc_valid && enc_ready) begin
            r_enc_cw_valid <= 1'b1;
            r_enc_cw       <= {w_enc_par, enc_data};
        end else if (enc_cw_ready) begin
            r_enc_cw_valid <= 1'b0;
        end
    end

    // S1: capture syndrome and the correction mode in force at accept time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_syn   <= '0;
            r_s1_cen   <= 1'b0;
        end else if (dec_ready) begin
            r_s1_valid <= dec_valid;
            if (dec_valid) begin
                r_s1_data <= dec_cw[DATA_W-1:0];
                r_s1_syn  <= w_dec_syn;
                r_s1_cen  <= correct_en;
            end
        end
    end

    // Syndrome-to-column match; parity columns are one-hot so no data flip there
    always_comb begin
        w_hit  = 1'b0;
        w_loc  = '0;
        w_flip = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (r_s1_syn == COLS[i][PAR_W-1:0]) begin
                w_hit     = 1'b1;
                w_loc     = LOC_W'(i);
                w_flip[i] = r_s1_cen;
            end
        end
        for (int unsigned j = 0; j < PAR_W; j++) begin
            if (r_s1_syn == (PAR_W'(1) << j)) begin
                w_hit = 1'b1;
                w_loc = LOC_W'(DATA_W + j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ce    <= 1'b0;
            r_out_ue    <= 1'b0;
            r_out_loc   <= '0;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= r_s1_data ^ w_flip;
                r_out_ce   <= w_hit;
                r_out_ue   <= (r_s1_syn != '0) && !w_hit;
                r_out_loc  <= w_loc;
            end
        end
    end

    // Clear dominates a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_ce_cnt <= '0;
            r_ue_cnt <= '0;
        end else if (r_out_valid && out_ready) begin
            if (r_out_ce && (r_ce_cnt != '1)) r_ce_cnt <= r_ce_cnt + CNT_W'(1);
            if (r_out_ue && (r_ue_cnt != '1)) r_ue_cnt <= r_ue_cnt + CNT_W'(1);
        end
    end

    assign enc_cw_valid = r_enc_cw_valid;
    assign enc_cw       = r_enc_cw;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_ce       = r_out_ce;
    assign out_ue       = r_out_ue;
    assign out_loc      = r_out_loc;
    assign ce_cnt       = r_ce_cnt;
    assign ue_cnt       = r_ue_cnt;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Self-checking bench for ecc_secded_pipe against a behavioural SEC-DED model.
module tb_ecc_secded_pipe;

    localparam int unsigned DATA_W = 23;
    localparam int unsigned PAR_W  = 6;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned CW_W   = 29;
    localparam int unsigned LOC_W  = 5;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ce;
        logic              ue;
        logic [LOC_W-1:0]  loc;
    } res_t;

    logic              clk;
    logic              rst;
    logic              enc_valid;
    logic              enc_ready;
    logic [DATA_W-1:0] enc_data;
    logic              enc_cw_valid;
    logic              enc_cw_ready;
    logic [CW_W-1:0]   enc_cw;
    logic              dec_valid;
    logic              dec_ready;
    logic [CW_W-1:0]   dec_cw;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_ce;
    logic              out_ue;
    logic [LOC_W-1:0]  out_loc;
    logic              correct_en;
    logic              cnt_clr;
    logic [CNT_W-1:0]  ce_cnt;
    logic [CNT_W-1:0]  ue_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned cols [CW_W];

    ecc_secded_pipe #(.DATA_W(DATA_W), .PAR_W(PAR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_data(enc_data),
        .enc_cw_valid(enc_cw_valid), .enc_cw_ready(enc_cw_ready), .enc_cw(enc_cw),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_cw(dec_cw),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ce(out_ce), .out_ue(out_ue), .out_loc(out_loc),
        .correct_en(correct_en), .cnt_clr(cnt_clr), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void build_model_cols();
        int n = 0;
        for (int v = 1; v < 64; v++) begin
            if (n < int'(DATA_W) && ($countones(v) >= 3) && ($countones(v) % 2 == 1)) begin
                cols[n] = v;
                n++;
            end
        end
        for (int j = 0; j < int'(PAR_W); j++) cols[DATA_W + j] = 1 << j;
    endfunction

    function automatic logic [CW_W-1:0] model_enc(logic [DATA_W-1:0] d);
        logic [PAR_W-1:0] p = '0;
        for (int i = 0; i < int'(DATA_W); i++) if (d[i]) p = p ^ PAR_W'(cols[i]);
        return {p, d};
    endfunction

    function automatic res_t model_dec(logic [CW_W-1:0] cw, logic cen);
        res_t             r;
        logic [CW_W-1:0]  re = model_enc(cw[DATA_W-1:0]);
        logic [PAR_W-1:0] syn = re[CW_W-1:DATA_W] ^ cw[CW_W-1:DATA_W];
        r = {cw[DATA_W-1:0], 1'b0, 1'b0, 5'd0};
        if (syn != '0) begin
            r.ue = 1'b1;
            for (int k = 0; k < int'(CW_W); k++) begin
                if (cols[k] == int'(syn)) begin
                    r.ue  = 1'b0;
                    r.ce  = 1'b1;
                    r.loc = LOC_W'(k);
                    if (k < int'(DATA_W) && cen) r.data[k] = ~r.data[k];
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CW_W-1:0] gen_cw();
        logic [CW_W-1:0] cw = model_enc(DATA_W'($urandom));
        int p0 = int'($urandom_range(CW_W - 1, 0));
        int p1 = (p0 + int'($urandom_range(CW_W - 1, 1))) % int'(CW_W);
        case ($urandom_range(4, 0))
            1, 2: cw[p0] = ~cw[p0];
            3: begin
                cw[p0] = ~cw[p0];
                cw[p1] = ~cw[p1];
            end
            4: cw = CW_W'($urandom);
            default: ;
        endcase
        return cw;
    endfunction

    function automatic int sat(int n);
        return (n > 3) ? 3 : n;
    endfunction

    // Drives one codeword, measures accept-to-out_valid latency, then consumes it
    task automatic dec_one(input logic [CW_W-1:0] cw, input logic cen, input logic clr,
                           output res_t r, output int lat);
        int w = 0;
        dec_cw = cw; correct_en = cen; dec_valid = 1'b1; out_ready = 1'b1;
        #1;
        while (!dec_ready && w < 10) begin step(); w++; end
        step();
        dec_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin step(); lat++; end
        r = {out_data, out_ce, out_ue, out_loc};
        cnt_clr = clr;
        step();
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({enc_cw_valid, enc_cw, out_valid, out_data, out_ce, out_ue, out_loc, ce_cnt, ue_cnt} !== '0) begin
            n_errors++;
            $display("FAIL reset_state got cwv=%b cw=%h ov=%b d=%h ce=%b ue=%b loc=%0d cc=%0d uc=%0d exp all 0",
                     enc_cw_valid, enc_cw, out_valid, out_data, out_ce, out_ue, out_loc, ce_cnt, ue_cnt);
        end
        n_checks++;
        if ({enc_ready, dec_ready} !== 2'b11) begin
            n_errors++;
            $display("FAIL reset_ready got %b exp 11", {enc_ready, dec_ready});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_encode();
        logic [CW_W-1:0] exp_cw = 29'h0380_0001;
        enc_valid = 1'b1; enc_data = 23'h1; enc_cw_ready = 1'b1;
        #1;
        n_checks++;
        if (enc_ready !== 1'b1) begin n_errors++; $display("FAIL enc_ready_idle got %b exp 1", enc_ready); end
        step();
        for (int c = 0; c < 3; c++) begin
            enc_valid = 1'b1; enc_data = 23'h2; enc_cw_ready = 1'b0;
            #1;
            n_checks++;
            if ({enc_cw_valid, enc_cw} !== {1'b1, exp_cw}) begin
                n_errors++;
                $display("FAIL enc_hold cyc %0d got v=%b cw=%h exp v=1 cw=%h", c, enc_cw_valid, enc_cw, exp_cw);
            end
            n_checks++;
            if (enc_ready !== 1'b0) begin n_errors++; $display("FAIL enc_ready_stall cyc %0d got %b exp 0", c, enc_ready); end
            step();
        end
        enc_valid = 1'b0; enc_cw_ready = 1'b1;
        #1;
        n_checks++;
        if (enc_ready !== 1'b1) begin n_errors++; $display("FAIL enc_ready_release got %b exp 1", enc_ready); end
        step();
        n_checks++;
        if (enc_cw_valid !== 1'b0) begin n_errors++; $display("FAIL enc_drain got %b exp 0", enc_cw_valid); end
    endtask

    task automatic test_enc_stream(input int n);
        logic [CW_W-1:0] q[$];
        logic [CW_W-1:0] prev_cw = '0;
        logic [CW_W-1:0] exp_cw;
        bit pending = 1'b0, prev_stall = 1'b0;
        int remaining = n, cyc = 0;
        while ((remaining > 0 || q.size() > 0) && cyc < 2000) begin
            if (!pending) begin
                enc_data  = DATA_W'($urandom);
                enc_valid = (remaining > 0) && ($urandom_range(3, 0) != 0);
            end
            enc_cw_ready = ($urandom_range(2, 0) != 0);
            #1;
            n_checks++;
            if (enc_cw_valid !== (q.size() != 0) ||
                enc_ready !== ((q.size() == 0) || enc_cw_ready)) begin
                n_errors++;
                $display("FAIL enc_stream_flags cyc %0d got v=%b rdy=%b exp v=%b rdy=%b", cyc,
                         enc_cw_valid, enc_ready, q.size() != 0, (q.size() == 0) || enc_cw_ready);
            end
            if (prev_stall) begin
                n_checks++;
                if (enc_cw !== prev_cw) begin
                    n_errors++;
                    $display("FAIL enc_stream_hold cyc %0d got %h exp %h", cyc, enc_cw, prev_cw);
                end
            end
            if (enc_cw_valid && enc_cw_ready && q.size() > 0) begin
                exp_cw = q.pop_front();
                n_checks++;
                if (enc_cw !== exp_cw) begin
                    n_errors++;
                    $display("FAIL enc_stream_cw cyc %0d got %h exp %h", cyc, enc_cw, exp_cw);
                end
            end
            if (enc_valid && enc_ready) begin
                q.push_back(model_enc(enc_data));
                remaining--;
                pending = 1'b0;
            end else begin
                pending = enc_valid;
            end
            prev_stall = enc_cw_valid && !enc_cw_ready;
            prev_cw = enc_cw;
            step();
            cyc++;
        end
        enc_valid = 1'b0; enc_cw_ready = 1'b1;
        n_checks++;
        if (remaining > 0 || q.size() > 0) begin
            n_errors++;
            $display("FAIL enc_stream_timeout got remaining=%0d queued=%0d exp 0", remaining, q.size());
        end
    endtask

    task automatic test_decode();
        logic [CW_W-1:0] t_cw  [5] = '{29'h0380_0021, 29'h0380_0021, 29'h0300_0001, 29'h0380_0002, 29'h0380_0001};
        logic            t_cen [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        res_t            t_exp [5] = '{{23'h1, 1'b1, 1'b0, 5'd5}, {23'h21, 1'b1, 1'b0, 5'd5},
                                       {23'h1, 1'b1, 1'b0, 5'd23}, {23'h2, 1'b0, 1'b1, 5'd0},
                                       {23'h1, 1'b0, 1'b0, 5'd0}};
        res_t r;
        int   lat;
        for (int k = 0; k < 5; k++) begin
            dec_one(t_cw[k], t_cen[k], 1'b0, r, lat);
            n_checks++;
            if (lat !== 2) begin n_errors++; $display("FAIL dec_latency case %0d got %0d exp 2", k, lat); end
            n_checks++;
            if (r !== t_exp[k]) begin
                n_errors++;
                $display("FAIL dec_result case %0d got d=%h ce=%b ue=%b loc=%0d exp d=%h ce=%b ue=%b loc=%0d", k,
                         r.data, r.ce, r.ue, r.loc, t_exp[k].data, t_exp[k].ce, t_exp[k].ue, t_exp[k].loc);
            end
        end
    endtask

    // rnd=0: back-to-back input with out_ready toggling; rnd=1: random valid/ready
    task automatic test_dec_stream(input int n, input bit rnd);
        res_t q[$];
        res_t got, prev = '0, exp;
        bit pending = 1'b0, prev_stall = 1'b0, exp_rdy;
        int remaining = n, cyc = 0, nce = 0, nue = 0;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        while ((remaining > 0 || q.size() > 0) && cyc < 3000) begin
            if (!pending) begin
                dec_cw     = gen_cw();
                correct_en = $urandom_range(1, 0) != 0;
                dec_valid  = (remaining > 0) && (!rnd || $urandom_range(3, 0) != 0);
            end
            out_ready = rnd ? ($urandom_range(2, 0) != 0) : (cyc % 2 == 0);
            #1;
            exp_rdy = !(q.size() == 2 && !out_ready);
            n_checks++;
            if (dec_ready !== exp_rdy) begin
                n_errors++;
                $display("FAIL dec_ready cyc %0d got %b exp %b", cyc, dec_ready, exp_rdy);
            end
            got = {out_data, out_ce, out_ue, out_loc};
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || got !== prev) begin
                    n_errors++;
                    $display("FAIL dec_hold cyc %0d got v=%b %h exp v=1 %h", cyc, out_valid, got, prev);
                end
            end
            if (out_valid && q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL dec_spurious cyc %0d got out_valid=1 exp 0", cyc);
            end else if (out_valid && out_ready) begin
                exp = q.pop_front();
                nce += int'(exp.ce);
                nue += int'(exp.ue);
                n_checks++;
                if (got !== exp) begin
                    n_errors++;
                    $display("FAIL dec_stream cyc %0d got d=%h ce=%b ue=%b loc=%0d exp d=%h ce=%b ue=%b loc=%0d",
                             cyc, got.data, got.ce, got.ue, got.loc, exp.data, exp.ce, exp.ue, exp.loc);
                end
            end
            if (dec_valid && dec_ready) begin
                q.push_back(model_dec(dec_cw, correct_en));
                remaining--;
                pending = 1'b0;
            end else begin
                pending = dec_valid;
            end
            prev_stall = out_valid && !out_ready;
            prev = got;
            step();
            cyc++;
        end
        dec_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (remaining > 0 || q.size() > 0) begin
            n_errors++;
            $display("FAIL dec_stream_timeout got remaining=%0d queued=%0d exp 0", remaining, q.size());
        end
        n_checks++;
        if (ce_cnt !== CNT_W'(sat(nce)) || ue_cnt !== CNT_W'(sat(nue))) begin
            n_errors++;
            $display("FAIL dec_stream_counts got ce=%0d ue=%0d exp ce=%0d ue=%0d", ce_cnt, ue_cnt, sat(nce), sat(nue));
        end
    endtask

    task automatic test_counters();
        res_t r;
        int   lat;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_checks++;
        if ({ce_cnt, ue_cnt} !== '0) begin
            n_errors++;
            $display("FAIL cnt_clear got ce=%0d ue=%0d exp 0 0", ce_cnt, ue_cnt);
        end
        for (int k = 1; k <= 5; k++) begin
            dec_one(29'h0380_0021, 1'b1, 1'b0, r, lat);
            n_checks++;
            if (ce_cnt !== CNT_W'(sat(k))) begin
                n_errors++;
                $display("FAIL ce_sat after %0d got %0d exp %0d", k, ce_cnt, sat(k));
            end
        end
        dec_one(29'h0380_0002, 1'b1, 1'b0, r, lat);
        n_checks++;
        if (ue_cnt !== CNT_W'(1)) begin n_errors++; $display("FAIL ue_inc got %0d exp 1", ue_cnt); end
        dec_one(29'h0380_0002, 1'b1, 1'b1, r, lat);
        n_checks++;
        if ({ce_cnt, ue_cnt} !== '0) begin
            n_errors++;
            $display("FAIL clr_wins got ce=%0d ue=%0d exp 0 0", ce_cnt, ue_cnt);
        end
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b0; enc_cw_ready = 1'b0;
        dec_valid = 1'b1; dec_cw = 29'h0380_0021; correct_en = 1'b1;
        enc_valid = 1'b1; enc_data = 23'h5;
        step();
        enc_valid = 1'b0;
        dec_cw = 29'h0380_0001;
        step();
        dec_valid = 1'b0;
        n_checks++;
        if ({out_valid, enc_cw_valid} !== 2'b11) begin
            n_errors++;
            $display("FAIL inflight_setup got ov=%b cwv=%b exp 1 1", out_valid, enc_cw_valid);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({out_valid, enc_cw_valid, out_data, out_ce, out_ue, out_loc, enc_cw} !== '0) begin
            n_errors++;
            $display("FAIL reset_inflight got ov=%b cwv=%b d=%h ce=%b ue=%b loc=%0d cw=%h exp all 0",
                     out_valid, enc_cw_valid, out_data, out_ce, out_ue, out_loc, enc_cw);
        end
        rst = 1'b0; out_ready = 1'b1; enc_cw_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if ({out_valid, enc_cw_valid} !== 2'b00) begin
                n_errors++;
                $display("FAIL reset_dropped cyc %0d got ov=%b cwv=%b exp 0 0", c, out_valid, enc_cw_valid);
            end
        end
    endtask

    initial begin
        rst = 1'b1; enc_valid = 1'b0; enc_data = '0; enc_cw_ready = 1'b1;
        dec_valid = 1'b0; dec_cw = '0; out_ready = 1'b1; correct_en = 1'b1; cnt_clr = 1'b0;
        build_model_cols();
        test_reset();
        test_encode();
        test_enc_stream(80);
        test_decode();
        test_dec_stream(8, 1'b0);
        test_dec_stream(300, 1'b1);
        test_counters();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
